// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Requests 128-bit lines from the instruction cache and keeps the most recent
// line in a single-entry buffer. Instructions are issued one per cycle from
// the buffer while decode is ready. A redirect can be served from the buffer
// without a cache access when the target lies in the buffered line.
//
// Parameters
//   RESET_PC       fetch address loaded on reset
//
// Ports
//   clock          single clock, all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   redirect       branch/jump redirect request; highest priority
//   redirect_pc    new fetch address; bits [1:0] ignored
//   stall          decode not ready; holds the presented instruction
//   ic_rd_en       cache read enable
//   ic_pc          cache line address, bits [3:0] zero (zero when not reading)
//   ic_dout_valid  cache line valid
//   ic_dout        cache line; word n at bits [32n+31:32n]
//   instr_valid    instr / instr_pc valid this cycle
//   instr          instruction word
//   instr_pc       byte address of instr
//
// Build option
//   FETCH_BYPASS_EN  when defined, a returning cache line is forwarded to the
//                    instruction outputs in the same cycle it is captured,
//                    removing one cycle from the miss latency.
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | first cycle after reset; nothing requested yet
//   REQ      | line request presented to the cache
//   CAPTURE  | request held, waiting for the line to come back
//   ISSUE    | line buffered, issuing the word selected by fetch_pc[3:2]

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  output logic         ic_rd_en,
  output logic [31:0]  ic_pc,
  input  logic         ic_dout_valid,
  input  logic [127:0] ic_dout,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_CAPTURE = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [127:0]   line_buf_q, line_buf_d;
  logic [27:0]    line_tag_q, line_tag_d;
  logic           buf_valid_q, buf_valid_d;

  logic [31:0]    redirect_pc_al;
  logic           redirect_hit;
  logic [31:0]    pc_inc;
  logic           line_end;
  logic [31:0]    buf_word;
  logic           unused_pc_bits;

  function automatic logic [31:0] word_sel(input logic [127:0] line,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign redirect_hit   = buf_valid_q && (redirect_pc[31:4] == line_tag_q);
  // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
  assign pc_inc         = fetch_pc_q + 32'd4;
  assign line_end       = (fetch_pc_q[3:2] == 2'b11);
  assign buf_word       = word_sel(line_buf_q, fetch_pc_q[3:2]);

`ifdef FETCH_BYPASS_EN
  logic [31:0] ic_word;
  assign ic_word = word_sel(ic_dout, fetch_pc_q[3:2]);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= {RESET_PC[31:2], 2'b00};
      line_buf_q  <= '0;
      line_tag_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      line_buf_q  <= line_buf_d;
      line_tag_q  <= line_tag_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    line_buf_d  = line_buf_q;
    line_tag_d  = line_tag_q;
    buf_valid_d = buf_valid_q;
    ic_rd_en    = 1'b0;
    ic_pc       = 32'h0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    instr_pc    = 32'h0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        ic_rd_en = 1'b1;
        ic_pc    = {fetch_pc_q[31:4], 4'b0000};
        state_d  = S_CAPTURE;
      end

      S_CAPTURE: begin
        ic_rd_en = 1'b1;
        ic_pc    = {fetch_pc_q[31:4], 4'b0000};
        // A redirect abandons the returning line, so it is neither captured
        // nor forwarded.
        if (ic_dout_valid && !redirect) begin
          line_buf_d  = ic_dout;
          line_tag_d  = fetch_pc_q[31:4];
          buf_valid_d = 1'b1;
          state_d     = S_ISSUE;
`ifdef FETCH_BYPASS_EN
          instr_valid = 1'b1;
          instr       = ic_word;
          instr_pc    = fetch_pc_q;
          if (!stall) begin
            fetch_pc_d = pc_inc;
            if (line_end) begin
              state_d     = S_REQ;
              buf_valid_d = 1'b0;
            end
          end
`endif
        end
      end

      S_ISSUE: begin
        instr_valid = 1'b1;
        instr       = buf_word;
        instr_pc    = fetch_pc_q;
        if (!stall) begin
          fetch_pc_d = pc_inc;
          if (line_end) begin
            state_d     = S_REQ;
            buf_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect wins over stall and over any sequential advance.
    if (redirect) begin
      fetch_pc_d = redirect_pc_al;
      if (state_q != S_IDLE && redirect_hit) begin
        state_d     = S_ISSUE;
        buf_valid_d = 1'b1;
      end else begin
        state_d     = S_REQ;
        buf_valid_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         stall = 1'b0;
  logic         ic_rd_en;
  logic [31:0]  ic_pc;
  logic         ic_dout_valid = 1'b0;
  logic [127:0] ic_dout = '0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         cache_hold = 1'b0;

  int tests = 0;
  int fails = 0;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .ic_rd_en     (ic_rd_en),
    .ic_pc        (ic_pc),
    .ic_dout_valid(ic_dout_valid),
    .ic_dout      (ic_dout),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [127:0] rom_line(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0000};
    return {rom_word(b + 32'd12), rom_word(b + 32'd8), rom_word(b + 32'd4), rom_word(b)};
  endfunction

  // Zero-wait cache: a request seen at an edge returns in the next cycle.
  always @(posedge clock) begin
    ic_dout_valid <= ic_rd_en && !cache_hold;
    ic_dout       <= rom_line(ic_pc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clock);
    #1;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    cache_hold = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int budget, output int n);
    n = 0;
    while (!(instr_valid && instr_pc == pc) && n < budget) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    tests++;
    if (!(instr_valid && instr_pc == pc)) begin
      fails++;
      $display("FAIL wait_pc: pc %h not presented within %0d cycles (valid %b pc %h)",
               pc, budget, instr_valid, instr_pc);
    end
  endtask

  // Scoreboard: every consumed instruction is popped and compared.
  logic [31:0] sb_q[$];
  bit          sb_en = 1'b0;

  always @(negedge clock) begin
    if (sb_en && !reset && instr_valid && !stall && !redirect) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, rom_word(e));
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        rd;
    logic [31:0] icpc;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic rd, input logic [31:0] icpc,
                              input logic v, input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.rd = rd; x.icpc = icpc; x.valid = v; x.pc = pc;
    return x;
  endfunction

  vec_t tbl[12];

  initial begin
    int n;
    bit redirected;

`ifdef FETCH_BYPASS_EN
    tbl[0]  = mk(0, 0, 32'h0,  0, 32'h0);
    tbl[1]  = mk(0, 1, 32'h0,  0, 32'h0);
    tbl[2]  = mk(0, 1, 32'h0,  1, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,  1, 32'h4);
    tbl[4]  = mk(0, 0, 32'h0,  1, 32'h8);
    tbl[5]  = mk(0, 0, 32'h0,  1, 32'hC);
    tbl[6]  = mk(0, 1, 32'h10, 0, 32'h0);
    tbl[7]  = mk(0, 1, 32'h10, 1, 32'h10);
    tbl[8]  = mk(0, 0, 32'h0,  1, 32'h14);
    tbl[9]  = mk(0, 0, 32'h0,  1, 32'h18);
    tbl[10] = mk(1, 0, 32'h0,  1, 32'h1C);
    tbl[11] = mk(0, 0, 32'h0,  1, 32'h1C);
`else
    tbl[0]  = mk(0, 0, 32'h0,  0, 32'h0);
    tbl[1]  = mk(0, 1, 32'h0,  0, 32'h0);
    tbl[2]  = mk(0, 1, 32'h0,  0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,  1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,  1, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,  1, 32'h8);
    tbl[6]  = mk(0, 0, 32'h0,  1, 32'hC);
    tbl[7]  = mk(0, 1, 32'h10, 0, 32'h0);
    tbl[8]  = mk(0, 1, 32'h10, 0, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,  1, 32'h10);
    tbl[10] = mk(1, 0, 32'h0,  1, 32'h14);
    tbl[11] = mk(0, 0, 32'h0,  1, 32'h14);
`endif

    // Under reset: everything zero.
    #12;
    chk("rst_rd_en", {31'h0, ic_rd_en}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // Reset release, sequential fetch, line crossing, stall hold.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(tbl[i].stall, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_rd_en", i), {31'h0, ic_rd_en}, {31'h0, tbl[i].rd});
      chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].valid});
      if (tbl[i].rd) chk($sformatf("tbl%0d_ic_pc", i), ic_pc, tbl[i].icpc);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), instr, rom_word(tbl[i].pc));
      end
    end

    // Stall for 5 cycles while B@4 is presented.
    do_reset();
    wait_pc(32'h0, 6, n);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc", instr_pc, 32'h4);
      chk("stall_instr", instr, rom_word(32'h4));
    end
    step(1'b0, 1'b0, 32'h0);
    chk("stall_release_pc", instr_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    chk("after_stall_pc", instr_pc, 32'h8);
    chk("after_stall_instr", instr, rom_word(32'h8));

    // Miss redirect to 0x20: latency, then in-line redirect hits.
    step(1'b0, 1'b1, 32'h20);
    for (int k = 1; k <= LAT; k++) begin
      step(1'b0, 1'b0, 32'h0);
      chk($sformatf("miss_T%0d_rd_en", k), {31'h0, ic_rd_en}, (k <= 2) ? 32'h1 : 32'h0);
      if (k <= 2) chk($sformatf("miss_T%0d_ic_pc", k), ic_pc, 32'h20);
      chk($sformatf("miss_T%0d_valid", k), {31'h0, instr_valid}, (k == LAT) ? 32'h1 : 32'h0);
    end
    chk("miss_pc", instr_pc, 32'h20);
    chk("miss_instr", instr, rom_word(32'h20));
    step(1'b0, 1'b1, 32'h28);
    chk("pre_hit_pc", instr_pc, 32'h24);
    step(1'b0, 1'b0, 32'h0);
    chk("hit_valid", {31'h0, instr_valid}, 32'h1);
    chk("hit_rd_en", {31'h0, ic_rd_en}, 32'h0);
    chk("hit_pc", instr_pc, 32'h28);
    chk("hit_instr", instr, rom_word(32'h28));
    step(1'b0, 1'b1, 32'h21);
    step(1'b0, 1'b0, 32'h0);
    chk("hit_back_rd_en", {31'h0, ic_rd_en}, 32'h0);
    chk("hit_back_pc", instr_pc, 32'h20);
    chk("hit_back_instr", instr, rom_word(32'h20));

    // Redirect with stall during CAPTURE of line 0x40.
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    chk("cap_req_ic_pc", ic_pc, 32'h40);
    step(1'b1, 1'b1, 32'h104);
    step(1'b0, 1'b0, 32'h0);
    chk("cap_redir_rd_en", {31'h0, ic_rd_en}, 32'h1);
    chk("cap_redir_ic_pc", ic_pc, 32'h100);
    chk("cap_redir_valid", {31'h0, instr_valid}, 32'h0);
    for (int k = 2; k <= LAT; k++) begin
      step(1'b0, 1'b0, 32'h0);
      chk($sformatf("cap_T%0d_valid", k), {31'h0, instr_valid}, (k == LAT) ? 32'h1 : 32'h0);
    end
    chk("cap_first_pc", instr_pc, 32'h104);
    chk("cap_first_instr", instr, rom_word(32'h104));

    // Cache slow to answer: CAPTURE waits.
    cache_hold = 1'b1;
    step(1'b0, 1'b1, 32'h80);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("hold_rd_en", {31'h0, ic_rd_en}, 32'h1);
      chk("hold_ic_pc", ic_pc, 32'h80);
      chk("hold_valid", {31'h0, instr_valid}, 32'h0);
    end
    cache_hold = 1'b0;
    wait_pc(32'h80, 4, n);
    chk("hold_instr", instr, rom_word(32'h80));

    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    wait_pc(32'hFFFF_FFF8, 5, n);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_last_pc", instr_pc, 32'hFFFF_FFFC);
    wait_pc(32'h0, 6, n);
    chk("wrap_bubbles", n, LAT);
    chk("wrap_instr", instr, rom_word(32'h0));

    // Asynchronous reset in the middle of CAPTURE.
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("arst_pre_rd_en", {31'h0, ic_rd_en}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_rd_en", {31'h0, ic_rd_en}, 32'h0);
    chk("arst_ic_pc", ic_pc, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_instr_pc", instr_pc, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("arst_idle_rd_en", {31'h0, ic_rd_en}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("arst_req_ic_pc", ic_pc, 32'h0);
    wait_pc(32'h0, 4, n);
    chk("arst_first_instr", instr, rom_word(32'h0));

    // Scoreboard run: random stalls and cache waits, one redirect midway.
    do_reset();
    sb_q.delete();
    for (int i = 0; i < 24; i++) sb_q.push_back(i * 4);
    sb_en = 1'b1;
    redirected = 1'b0;
    for (int c = 0; c < 600 && (sb_q.size() != 0 || !redirected); c++) begin
      @(posedge clock);
      #1;
      cache_hold = ($urandom_range(0, 3) == 0);
      if (!redirected && sb_q.size() <= 12) begin
        sb_q.delete();
        for (int k = 0; k < 20; k++) sb_q.push_back(32'h1F8 + k * 4);
        redirect = 1'b1;
        redirect_pc = 32'h1F9;
        stall = $urandom_range(0, 1);
        redirected = 1'b1;
      end else begin
        redirect = 1'b0;
        stall = ($urandom_range(0, 2) == 0);
      end
      @(negedge clock);
      #1;
    end
    sb_en = 1'b0;
    chk("sb_redirected", {31'h0, redirected}, 32'h1);
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
